// File: rtl/msu_axis_unpack.sv
// Host-side deframer: collects a little-endian AXI-stream job descriptor
// {init_value, end_cnt, start_cnt} and presents it on a valid/ready job port.
module msu_axis_unpack #(
    parameter int unsigned AXI_LEN  = 32,
    parameter int unsigned T_LEN    = 64,
    parameter int unsigned DAT_BITS = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [AXI_LEN-1:0]    s_axis_tdata,
    input  logic [AXI_LEN/8-1:0]  s_axis_tkeep,
    input  logic                  s_axis_tlast,

    output logic                  job_valid,
    input  logic                  job_ready,
    output logic [T_LEN-1:0]      start_cnt,
    output logic [T_LEN-1:0]      end_cnt,
    output logic [DAT_BITS-1:0]   init_value,
    output logic                  err_short,
    output logic                  err_long
);

    localparam int unsigned PAY_BITS  = 2 * T_LEN + DAT_BITS;
    localparam int unsigned NUM_WORDS = (PAY_BITS + AXI_LEN - 1) / AXI_LEN;
    localparam int unsigned KEEP_W    = AXI_LEN / 8;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_word_idx;
    logic [PAY_BITS-1:0]   r_shadow;
    logic                  r_err_short;
    logic                  r_err_long;
    logic                  r_tready;
    logic                  r_job_valid;

    logic                  w_xfer;
    logic                  w_last_word;
    logic                  w_wr_en;
    logic                  w_set_short;
    logic                  w_set_long;
    logic                  w_release;
    logic                  w_tready_nxt;
    logic                  w_valid_nxt;
    logic [AXI_LEN-1:0]    w_wdata;
    logic [PAY_BITS-1:0]   w_shadow_nxt;

    assign w_xfer      = s_axis_tvalid && r_tready;
    assign w_last_word = (r_word_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: begin
                if (w_xfer) begin
                    if (w_last_word) begin
                        w_state_nxt = s_axis_tlast ? HOLD : DRAIN;
                    end else if (s_axis_tlast) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            DRAIN: begin
                if (w_xfer && s_axis_tlast) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_job_valid && job_ready) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Output / control decode; tready and job_valid follow the next state
    always_comb begin
        w_wr_en      = 1'b0;
        w_set_short  = 1'b0;
        w_set_long   = 1'b0;
        w_release    = 1'b0;
        w_tready_nxt = 1'b0;
        w_valid_nxt  = 1'b0;

        w_wr_en      = (r_state == COLLECT) && w_xfer;
        w_set_short  = w_wr_en && s_axis_tlast && !w_last_word;
        w_set_long   = w_wr_en && w_last_word && !s_axis_tlast;
        w_release    = (r_state == HOLD) && r_job_valid && job_ready;
        w_tready_nxt = (w_state_nxt != HOLD);
        w_valid_nxt  = (w_state_nxt == HOLD);
    end

    // Byte-enable masking of the incoming word
    always_comb begin
        w_wdata = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            w_wdata[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
        end
    end

    // Merge the word into slice word_idx; bits beyond PAY_BITS fall away
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int b = 0; b < PAY_BITS; b++) begin
            if ((32'(b) / AXI_LEN) == 32'(r_word_idx)) begin
                w_shadow_nxt[b] = w_wdata[32'(b) % AXI_LEN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_idx  <= '0;
            r_shadow    <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_tready    <= 1'b0;
            r_job_valid <= 1'b0;
        end else begin
            r_tready    <= w_tready_nxt;
            r_job_valid <= w_valid_nxt;
            if (w_release) begin
                r_word_idx  <= '0;
                r_shadow    <= '0;
                r_err_short <= 1'b0;
                r_err_long  <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_shadow <= w_shadow_nxt;
                    if (!w_last_word) begin
                        r_word_idx <= r_word_idx + IDX_W'(1);
                    end
                end
                if (w_set_short) begin
                    r_err_short <= 1'b1;
                end
                if (w_set_long) begin
                    r_err_long <= 1'b1;
                end
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign job_valid     = r_job_valid;
    assign start_cnt     = r_shadow[T_LEN-1:0];
    assign end_cnt       = r_shadow[2*T_LEN-1:T_LEN];
    assign init_value    = r_shadow[PAY_BITS-1:2*T_LEN];
    assign err_short     = r_err_short;
    assign err_long      = r_err_long;

endmodule

// File: tb/tb_msu_axis_unpack.sv
// Directed bench for msu_axis_unpack with AXI_LEN=32, T_LEN=64, DAT_BITS=128 (8 words/frame).
module tb_msu_axis_unpack;

    localparam int unsigned AXI_LEN  = 32;
    localparam int unsigned T_LEN    = 64;
    localparam int unsigned DAT_BITS = 128;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [AXI_LEN-1:0]   s_axis_tdata;
    logic [AXI_LEN/8-1:0] s_axis_tkeep;
    logic                 s_axis_tlast;
    logic                 job_valid;
    logic                 job_ready;
    logic [T_LEN-1:0]     start_cnt;
    logic [T_LEN-1:0]     end_cnt;
    logic [DAT_BITS-1:0]  init_value;
    logic                 err_short;
    logic                 err_long;

    int n_cmp = 0;
    int n_bad = 0;

    msu_axis_unpack #(
        .AXI_LEN  (AXI_LEN),
        .T_LEN    (T_LEN),
        .DAT_BITS (DAT_BITS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .start_cnt     (start_cnt),
        .end_cnt       (end_cnt),
        .init_value    (init_value),
        .err_short     (err_short),
        .err_long      (err_long)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        n = 0;
        while (s_axis_tready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_word_timeout word=%h tready stayed %b", d, s_axis_tready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (job_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", job_valid); end
        n_cmp++; if (start_cnt !== 64'h0) begin n_bad++; $display("FAIL rst_start got %h want 0", start_cnt); end
        n_cmp++; if (end_cnt !== 64'h0) begin n_bad++; $display("FAIL rst_end got %h want 0", end_cnt); end
        n_cmp++; if (init_value !== 128'h0) begin n_bad++; $display("FAIL rst_init got %h want 0", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b00) begin n_bad++; $display("FAIL rst_err got %b want 00", {err_short, err_long}); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rel_tready_now got %b want 0", s_axis_tready); end
        @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rel_tready_cyc0 got %b want 0", s_axis_tready); end
        @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL rel_tready_cyc1 got %b want 1", s_axis_tready); end
    endtask

    task automatic test_nominal();
        logic [31:0] d;
        job_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = (i == 2) ? 32'h0001_86A0 : (i == 4) ? 32'h0000_0002 : 32'h0;
            send_word(d, 4'hF, i == 7);
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL nom_valid got %b want 1", job_valid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL nom_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (start_cnt !== 64'h0) begin n_bad++; $display("FAIL nom_start got %h want 0", start_cnt); end
        n_cmp++; if (end_cnt !== 64'h186A0) begin n_bad++; $display("FAIL nom_end got %h want 186a0", end_cnt); end
        n_cmp++; if (init_value !== 128'h2) begin n_bad++; $display("FAIL nom_init got %h want 2", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b00) begin n_bad++; $display("FAIL nom_err got %b want 00", {err_short, err_long}); end
        @(negedge clk);
        n_cmp++; if (job_valid !== 1'b0) begin n_bad++; $display("FAIL nom_drop got %b want 0", job_valid); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL nom_rearm got %b want 1", s_axis_tready); end
        n_cmp++; if (end_cnt !== 64'h0) begin n_bad++; $display("FAIL nom_clear got %h want 0", end_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        job_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = (i == 2) ? 32'h0001_86A0 : (i == 4) ? 32'h0000_0002 : 32'h0;
            send_word(d, 4'hF, i == 7);
        end
        // Next frame is a single word with tlast; it must wait out HOLD
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1111_1111;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid c=%0d got %b want 1", c, job_valid); end
            n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp_tready c=%0d got %b want 0", c, s_axis_tready); end
            n_cmp++; if (start_cnt !== 64'h0) begin n_bad++; $display("FAIL bp_start c=%0d got %h want 0", c, start_cnt); end
            n_cmp++; if (end_cnt !== 64'h186A0) begin n_bad++; $display("FAIL bp_end c=%0d got %h want 186a0", c, end_cnt); end
            n_cmp++; if (init_value !== 128'h2) begin n_bad++; $display("FAIL bp_init c=%0d got %h want 2", c, init_value); end
            @(negedge clk);
        end
        job_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (job_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop got %b want 0", job_valid); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL bp_rearm got %b want 1", s_axis_tready); end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL w1_valid got %b want 1", job_valid); end
        n_cmp++; if (start_cnt !== 64'h1111_1111) begin n_bad++; $display("FAIL w1_start got %h want 11111111", start_cnt); end
        n_cmp++; if (end_cnt !== 64'h0) begin n_bad++; $display("FAIL w1_end got %h want 0", end_cnt); end
        n_cmp++; if (init_value !== 128'h0) begin n_bad++; $display("FAIL w1_init got %h want 0", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b10) begin n_bad++; $display("FAIL w1_err got %b want 10", {err_short, err_long}); end
        @(negedge clk);
    endtask

    task automatic test_short();
        job_ready = 1'b1;
        send_word(32'h1111_1111, 4'hF, 1'b0);
        send_word(32'h2222_2222, 4'hF, 1'b0);
        send_word(32'h3333_3333, 4'hF, 1'b1);
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL sh_valid got %b want 1", job_valid); end
        n_cmp++; if (start_cnt !== 64'h2222_2222_1111_1111) begin n_bad++; $display("FAIL sh_start got %h want 2222222211111111", start_cnt); end
        n_cmp++; if (end_cnt !== 64'h3333_3333) begin n_bad++; $display("FAIL sh_end got %h want 33333333", end_cnt); end
        n_cmp++; if (init_value !== 128'h0) begin n_bad++; $display("FAIL sh_init got %h want 0", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b10) begin n_bad++; $display("FAIL sh_err got %b want 10", {err_short, err_long}); end
    endtask

    task automatic test_long();
        job_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_word(32'hA000_0000 + 32'(i), 4'hF, i == 9);
            if (i == 7) begin
                n_cmp++; if (job_valid !== 1'b0) begin n_bad++; $display("FAIL lg_early_valid got %b want 0", job_valid); end
                n_cmp++; if (err_long !== 1'b1) begin n_bad++; $display("FAIL lg_early_err got %b want 1", err_long); end
                n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL lg_drain_tready got %b want 1", s_axis_tready); end
            end
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL lg_valid got %b want 1", job_valid); end
        n_cmp++; if (start_cnt !== 64'hA000_0001_A000_0000) begin n_bad++; $display("FAIL lg_start got %h", start_cnt); end
        n_cmp++; if (end_cnt !== 64'hA000_0003_A000_0002) begin n_bad++; $display("FAIL lg_end got %h", end_cnt); end
        n_cmp++; if (init_value !== 128'hA000_0007_A000_0006_A000_0005_A000_0004) begin n_bad++; $display("FAIL lg_init got %h", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b01) begin n_bad++; $display("FAIL lg_err got %b want 01", {err_short, err_long}); end
    endtask

    task automatic test_keep_bubbles();
        logic [31:0] w [8];
        int gap;
        w[0] = 32'hAABB_CCDD; w[1] = 32'h1234_5678; w[2] = 32'hDEAD_BEEF; w[3] = 32'h0BAD_F00D;
        w[4] = 32'h5555_5555; w[5] = 32'h0;         w[6] = 32'h0;         w[7] = 32'h0;
        job_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                gap = int'($urandom_range(0, 3));
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = $urandom;
                s_axis_tkeep  = 4'hF;
                s_axis_tlast  = 1'b1;
                repeat (gap) @(negedge clk);
            end
            send_word(w[i], (i == 0) ? 4'b0011 : 4'hF, i == 7);
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL kb_valid got %b want 1", job_valid); end
        n_cmp++; if (start_cnt !== 64'h1234_5678_0000_CCDD) begin n_bad++; $display("FAIL kb_start got %h want 123456780000ccdd", start_cnt); end
        n_cmp++; if (end_cnt !== 64'h0BAD_F00D_DEAD_BEEF) begin n_bad++; $display("FAIL kb_end got %h want 0badf00ddeadbeef", end_cnt); end
        n_cmp++; if (init_value !== 128'h5555_5555) begin n_bad++; $display("FAIL kb_init got %h want 55555555", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b00) begin n_bad++; $display("FAIL kb_err got %b want 00", {err_short, err_long}); end
    endtask

    task automatic test_reset_midframe();
        job_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(32'hFFFF_FFFF, 4'hF, 1'b0);
        s_axis_tvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rm_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (start_cnt !== 64'h0) begin n_bad++; $display("FAIL rm_start got %h want 0", start_cnt); end
        @(negedge clk);
        reset_n = 1'b1;

        // Reset while a completed job is being held
        job_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(32'hC0C0_C0C0, 4'hF, i == 7);
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL rh_pre_valid got %b want 1", job_valid); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (job_valid !== 1'b0) begin n_bad++; $display("FAIL rh_valid got %b want 0", job_valid); end
        n_cmp++; if (init_value !== 128'h0) begin n_bad++; $display("FAIL rh_init got %h want 0", init_value); end
        @(negedge clk);
        reset_n = 1'b1;

        job_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(32'(i + 1), 4'hF, i == 7);
        s_axis_tvalid = 1'b0;
        n_cmp++; if (job_valid !== 1'b1) begin n_bad++; $display("FAIL rn_valid got %b want 1", job_valid); end
        n_cmp++; if (start_cnt !== 64'h0000_0002_0000_0001) begin n_bad++; $display("FAIL rn_start got %h", start_cnt); end
        n_cmp++; if (end_cnt !== 64'h0000_0004_0000_0003) begin n_bad++; $display("FAIL rn_end got %h", end_cnt); end
        n_cmp++; if (init_value !== 128'h0000_0008_0000_0007_0000_0006_0000_0005) begin n_bad++; $display("FAIL rn_init got %h", init_value); end
        n_cmp++; if ({err_short, err_long} !== 2'b00) begin n_bad++; $display("FAIL rn_err got %b want 00", {err_short, err_long}); end
        @(negedge clk);
    endtask

    initial begin
        reset_n       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        job_ready     = 1'b0;

        test_reset();
        test_nominal();
        test_backpressure();
        test_short();
        test_long();
        test_keep_bubbles();
        test_reset_midframe();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish got timeout want completion");
        $fatal(1);
    end

endmodule
